// File: rtl/divider_pkg.sv
// Shared types and helpers for the restoring divider.
// DIVIDER_SIGNED_EN (optional) adds signed operation to the divider.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // All-ones pattern of the requested width; used as the divide-by-zero quotient.
  function automatic logic [63:0] div_zero_quotient(input int width);
    return (64'd1 << width) - 64'd1;
  endfunction

endpackage

// File: rtl/divider_if.sv
// Request/response bundle between the execute stage and the divider.
// DIVIDER_SIGNED_EN adds the signed_op request bit.
interface divider_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
`ifdef DIVIDER_SIGNED_EN
  logic             signed_op;
`endif
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_by_zero;

`ifdef DIVIDER_SIGNED_EN
  modport master (output start, dividend, divisor, signed_op,
                  input  quotient, remainder, busy, done, div_by_zero);
  modport slave  (input  start, dividend, divisor, signed_op,
                  output quotient, remainder, busy, done, div_by_zero);
`else
  modport master (output start, dividend, divisor,
                  input  quotient, remainder, busy, done, div_by_zero);
  modport slave  (input  start, dividend, divisor,
                  output quotient, remainder, busy, done, div_by_zero);
`endif
endinterface

// File: rtl/divider_step.sv
// One restoring shift-subtract iteration, purely combinational.
// Kept separate so two copies can be chained for 2 bits per cycle.
module divider_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;

  always_comb begin
    shifted = {rem_in, dvd_bit};
    trial   = shifted - {2'b00, divisor};
    // A set top bit means the trial went negative: restore.
    q_bit   = ~trial[WIDTH+1];
    rem_out = q_bit ? trial[WIDTH:0] : shifted[WIDTH:0];
  end
endmodule

// File: rtl/divider.sv
// Multi-cycle restoring divider, one quotient bit per clock, start/done handshake.
// Define DIVIDER_SIGNED_EN to add signed_op (magnitude divide plus sign fix-up).
module divider
  import divider_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic      clk,
  input logic      rst,
  divider_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] DIV_ZERO_QUOTIENT = WIDTH'(div_zero_quotient(WIDTH));

  div_state_e       state_q, state_d;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dsr_q;
  logic [WIDTH-1:0] quo_q;
  logic [CNT_W-1:0] cnt_q;
  logic             neg_q_q, neg_r_q;
  logic [WIDTH-1:0] quotient_q, remainder_q;
  logic             dbz_q;

  logic [WIDTH:0]   rem_nxt;
  logic             q_bit;
  logic [WIDTH-1:0] q_mag, r_mag;
  logic             sop;
  logic             last_iter;
  logic             dsr_zero;

`ifdef DIVIDER_SIGNED_EN
  assign sop = bus.signed_op;
`else
  assign sop = 1'b0;
`endif

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic s);
    return (s && v[WIDTH-1]) ? -v : v;
  endfunction

  divider_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .dvd_bit (dvd_q[WIDTH-1]),
    .divisor (dsr_q),
    .rem_out (rem_nxt),
    .q_bit   (q_bit)
  );

  assign last_iter = (cnt_q == LAST_CNT);
  assign dsr_zero  = (bus.divisor == '0);
  assign q_mag     = {quo_q[WIDTH-2:0], q_bit};
  assign r_mag     = rem_nxt[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = dsr_zero ? DONE : BUSY;
      BUSY:    if (last_iter) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q       <= '0;
      dvd_q       <= '0;
      dsr_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          dvd_q   <= mag(bus.dividend, sop);
          dsr_q   <= mag(bus.divisor, sop);
          rem_q   <= '0;
          quo_q   <= '0;
          cnt_q   <= '0;
          neg_q_q <= sop & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
          neg_r_q <= sop & bus.dividend[WIDTH-1];
          dbz_q   <= dsr_zero;
          // Divide by zero skips BUSY, so results land on this edge.
          if (dsr_zero) begin
            quotient_q  <= DIV_ZERO_QUOTIENT;
            remainder_q <= bus.dividend;
          end
        end
        BUSY: begin
          rem_q <= rem_nxt;
          quo_q <= q_mag;
          dvd_q <= {dvd_q[WIDTH-2:0], 1'b0};
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_iter) begin
            quotient_q  <= neg_q_q ? -q_mag : q_mag;
            remainder_q <= neg_r_q ? -r_mag : r_mag;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = (state_q == DONE);
endmodule

// File: tb/tb_divider.sv
// Directed bench for divider (WIDTH=32); signed vectors enabled by DIVIDER_SIGNED_EN.
module tb_divider;
  localparam int W = 32;

  typedef struct {
    logic [W-1:0] dvd;
    logic [W-1:0] dsr;
    logic         sgn;
    logic [W-1:0] exp_q;
    logic [W-1:0] exp_r;
    logic         exp_z;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  divider_if #(.WIDTH(W)) bus ();
  divider #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_start(input vec_t v);
    bus.start    = 1'b1;
    bus.dividend = v.dvd;
    bus.divisor  = v.dsr;
`ifdef DIVIDER_SIGNED_EN
    bus.signed_op = v.sgn;
`endif
  endtask

  task automatic run_op(input vec_t v, input string tag);
    int lat;
    @(negedge clk);
    drive_start(v);
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0;
    while (!bus.done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), v.exp_z ? 64'd0 : 64'(W));
    chk({tag, " quotient"}, 64'(bus.quotient), 64'(v.exp_q));
    chk({tag, " remainder"}, 64'(bus.remainder), 64'(v.exp_r));
    chk({tag, " div_by_zero"}, 64'(bus.div_by_zero), 64'(v.exp_z));
    @(posedge clk); #1;
    chk({tag, " done pulse width"}, 64'(bus.done), 64'd0);
    chk({tag, " idle after done"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    int   ndone, first_done;
    logic [W-1:0] prev_q, q_at_done;
    vec_t v;

    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
`ifdef DIVIDER_SIGNED_EN
    bus.signed_op = 1'b0;
`endif

    vecs.push_back('{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0});
    vecs.push_back('{32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0,          1'b0});
    vecs.push_back('{32'd3,          32'h8000_0000,  1'b0, 32'd0,          32'd3,          1'b0});
    vecs.push_back('{32'd5,          32'd0,          1'b0, 32'hFFFF_FFFF,  32'd5,          1'b1});
    vecs.push_back('{32'd9,          32'd3,          1'b0, 32'd3,          32'd0,          1'b0});
    vecs.push_back('{32'd0,          32'd5,          1'b0, 32'd0,          32'd0,          1'b0});
    vecs.push_back('{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 32'd1,          32'd0,          1'b0});
    vecs.push_back('{32'hDEAD_BEEF,  32'h10,         1'b0, 32'h0DEA_DBEE,  32'hF,          1'b0});
    vecs.push_back('{32'd1000000,    32'd1000,       1'b0, 32'd1000,       32'd0,          1'b0});
    vecs.push_back('{32'h8000_0000,  32'd3,          1'b0, 32'h2AAA_AAAA,  32'd2,          1'b0});
    vecs.push_back('{32'hFFFF_FFF9,  32'd2,          1'b0, 32'h7FFF_FFFC,  32'd1,          1'b0});
`ifdef DIVIDER_SIGNED_EN
    vecs.push_back('{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0});
    vecs.push_back('{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          1'b0});
    vecs.push_back('{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          1'b0});
    vecs.push_back('{32'hFFFF_FFF9,  32'hFFFF_FFFE,  1'b1, 32'd3,          32'hFFFF_FFFF,  1'b0});
    vecs.push_back('{32'hFFFF_FFFB,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFB,  1'b1});
`endif

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset quotient", 64'(bus.quotient), 64'd0);
    chk("reset remainder", 64'(bus.remainder), 64'd0);
    chk("reset busy", 64'(bus.busy), 64'd0);
    chk("reset done", 64'(bus.done), 64'd0);
    chk("reset div_by_zero", 64'(bus.div_by_zero), 64'd0);
    rst = 1'b0;

    foreach (vecs[i]) run_op(vecs[i], $sformatf("vec%0d", i));

    // Start while busy is ignored; previous result stays visible during BUSY.
    prev_q = vecs[vecs.size()-1].exp_q;
    ndone = 0; first_done = -1; q_at_done = '0;
    @(negedge clk);
    drive_start(vecs[0]);
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k == 5) begin
        chk("busy holds prev quotient", 64'(bus.quotient), 64'(prev_q));
        chk("busy flag in BUSY", 64'(bus.busy), 64'd1);
      end
      if (k == 9) begin
        bus.start = 1'b1; bus.dividend = 32'd50; bus.divisor = 32'd5;
      end
      if (k == 10) bus.start = 1'b0;
      if (bus.done) begin
        ndone++;
        if (first_done < 0) begin first_done = k; q_at_done = bus.quotient; end
      end
    end
    chk("ignored start done count", 64'(ndone), 64'd1);
    chk("ignored start latency", 64'(first_done), 64'(W));
    chk("ignored start quotient", 64'(q_at_done), 64'd14);
    v = '{32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 1'b0};
    run_op(v, "after ignored start");

    // Reset in the middle of an operation
    @(negedge clk);
    drive_start(vecs[0]);
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (14) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midreset busy", 64'(bus.busy), 64'd0);
    chk("midreset done", 64'(bus.done), 64'd0);
    chk("midreset quotient", 64'(bus.quotient), 64'd0);
    chk("midreset remainder", 64'(bus.remainder), 64'd0);
    chk("midreset div_by_zero", 64'(bus.div_by_zero), 64'd0);
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.done) ndone++;
    end
    chk("midreset no done", 64'(ndone), 64'd0);
    v = '{32'd20, 32'd6, 1'b0, 32'd3, 32'd2, 1'b0};
    run_op(v, "after reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
